rx_frame_sequencer: RTL and testbench

//   Receive-side frame controller for the UART RX core. Tracks the serial line
//   and sequences the RX datapath: drives the one-hot state and bit-width count

---
 rtl/rx_frame_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_rx_frame_sequencer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/rx_frame_sequencer.sv
// UART receive frame sequencer: tracks start/data/parity/stop bits on the
// oversampled serial line, majority-votes each bit and flags framing errors.
module rx_frame_sequencer #(
   parameter int OVERSAMPLE = 16,
   parameter int ACQ_POINT  = 7,
   parameter int DATA_BITS  = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable_i,
   input  logic       baud_tick_i,
   input  logic       rx_i,
   input  logic       p_ParityEnable_i,
   output logic [4:0] state_o,
   output logic [3:0] bit_width_cnt_o,
   output logic       bit_o,
   output logic       bit_synch_o,
   output logic       frame_done_o,
   output logic       frame_err_o,
   output logic       start_err_o,
   output logic       busy_o
);

   localparam logic [3:0] CNT_MAX  = 4'(OVERSAMPLE - 1);
   localparam logic [3:0] ACQ_CNT  = 4'(ACQ_POINT);
   localparam logic [3:0] LAST_IDX = 4'(DATA_BITS - 1);

   typedef enum logic [4:0] {
      S_IDLE   = 5'b00001,
      S_START  = 5'b00010,
      S_DATA   = 5'b00100,
      S_PARITY = 5'b01000,
      S_STOP   = 5'b10000
   } state_t;

   state_t     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic [3:0] idx_q, idx_d;
   logic [1:0] hist_q, hist_d;
   logic       par_q, par_d;
   logic       bit_q, bit_d;
   logic       sync_q, sync_d;
   logic       done_q, done_d;
   logic       ferr_q, ferr_d;
   logic       serr_q, serr_d;
   logic       maj_s;
   logic       at_acq_s;
   logic       at_wrap_s;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

   // The current sample plus the two previous ticks form the voting window.
   assign maj_s     = maj3(hist_q[1], hist_q[0], rx_i);
   assign at_acq_s  = (cnt_q == ACQ_CNT);
   assign at_wrap_s = (cnt_q == CNT_MAX);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      hist_d  = hist_q;
      par_d   = par_q;
      bit_d   = bit_q;
      sync_d  = 1'b0;
      done_d  = 1'b0;
      ferr_d  = ferr_q;
      serr_d  = 1'b0;
      if (!enable_i) begin
         state_d = S_IDLE;
         cnt_d   = 4'd0;
         idx_d   = 4'd0;
         hist_d  = 2'b11;
         par_d   = 1'b0;
         bit_d   = 1'b1;
         ferr_d  = 1'b0;
      end else if (baud_tick_i) begin
         hist_d = {hist_q[0], rx_i};
         cnt_d  = at_wrap_s ? 4'd0 : cnt_q + 4'd1;
         case (state_q)
            S_IDLE: begin
               cnt_d = 4'd0;
               // Only a 1->0 transition starts a frame, so a held break is ignored.
               if (!rx_i && hist_q[0]) begin
                  state_d = S_START;
                  par_d   = p_ParityEnable_i;
                  ferr_d  = 1'b0;
               end else begin
                  state_d = S_IDLE;
               end
            end
            S_START: begin
               if (at_acq_s && maj_s) begin
                  state_d = S_IDLE;
                  cnt_d   = 4'd0;
                  serr_d  = 1'b1;
               end else if (at_wrap_s) begin
                  state_d = S_DATA;
                  idx_d   = 4'd0;
               end else begin
                  state_d = S_START;
               end
            end
            S_DATA: begin
               if (at_acq_s) begin
                  bit_d  = maj_s;
                  sync_d = 1'b1;
               end else if (at_wrap_s) begin
                  if (idx_q == LAST_IDX) begin
                     idx_d   = 4'd0;
                     state_d = par_q ? S_PARITY : S_STOP;
                  end else begin
                     idx_d = idx_q + 4'd1;
                  end
               end else begin
                  state_d = S_DATA;
               end
            end
            S_PARITY: begin
               if (at_acq_s) begin
                  bit_d  = maj_s;
                  sync_d = 1'b1;
               end else if (at_wrap_s) begin
                  state_d = S_STOP;
               end else begin
                  state_d = S_PARITY;
               end
            end
            S_STOP: begin
               // Leave at mid-bit so the next start edge can be caught immediately.
               if (at_acq_s) begin
                  done_d  = 1'b1;
                  ferr_d  = ~maj_s;
                  state_d = S_IDLE;
                  cnt_d   = 4'd0;
               end else begin
                  state_d = S_STOP;
               end
            end
            default: begin
               state_d = S_IDLE;
               cnt_d   = 4'd0;
               idx_d   = 4'd0;
            end
         endcase
      end else begin
         state_d = state_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         idx_q   <= 4'd0;
         hist_q  <= 2'b11;
         par_q   <= 1'b0;
         bit_q   <= 1'b1;
         sync_q  <= 1'b0;
         done_q  <= 1'b0;
         ferr_q  <= 1'b0;
         serr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         hist_q  <= hist_d;
         par_q   <= par_d;
         bit_q   <= bit_d;
         sync_q  <= sync_d;
         done_q  <= done_d;
         ferr_q  <= ferr_d;
         serr_q  <= serr_d;
      end
   end

   assign state_o         = state_q;
   assign bit_width_cnt_o = cnt_q;
   assign bit_o           = bit_q;
   assign bit_synch_o     = sync_q;
   assign frame_done_o    = done_q;
   assign frame_err_o     = ferr_q;
   assign start_err_o     = serr_q;
   assign busy_o          = (state_q != S_IDLE);

endmodule

// File: tb/tb_rx_frame_sequencer.sv
// Directed bench for rx_frame_sequencer: serial frames are driven one tick per
// clock, expected bits and stop-bit results are queued and popped on strobes.
module tb_rx_frame_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       enable_i;
   logic       baud_tick_i;
   logic       rx_i;
   logic       p_ParityEnable_i;
   logic [4:0] state_o;
   logic [3:0] bit_width_cnt_o;
   logic       bit_o;
   logic       bit_synch_o;
   logic       frame_done_o;
   logic       frame_err_o;
   logic       start_err_o;
   logic       busy_o;

   localparam logic [4:0] ST_IDLE   = 5'b00001;
   localparam logic [4:0] ST_START  = 5'b00010;
   localparam logic [4:0] ST_DATA   = 5'b00100;
   localparam logic [4:0] ST_PARITY = 5'b01000;

   rx_frame_sequencer dut (
      .clk              (clk),
      .rst              (rst),
      .enable_i         (enable_i),
      .baud_tick_i      (baud_tick_i),
      .rx_i             (rx_i),
      .p_ParityEnable_i (p_ParityEnable_i),
      .state_o          (state_o),
      .bit_width_cnt_o  (bit_width_cnt_o),
      .bit_o            (bit_o),
      .bit_synch_o      (bit_synch_o),
      .frame_done_o     (frame_done_o),
      .frame_err_o      (frame_err_o),
      .start_err_o      (start_err_o),
      .busy_o           (busy_o)
   );

   always #5 clk = ~clk;

   int         n_cmp = 0;
   int         n_err = 0;
   int         n_sync;
   int         n_serr;
   int         par_ticks;
   logic [4:0] seen;
   logic       exp_bits[$];
   logic       exp_ferr[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One baud tick: drive the line, take the edge, then score any strobes.
   task automatic tick(input logic rx);
      rx_i = rx;
      @(posedge clk);
      #1;
      seen = seen | state_o;
      if (state_o === ST_PARITY) par_ticks++;
      check("busy", busy_o, state_o !== ST_IDLE);
      if (bit_synch_o) begin
         n_sync++;
         if (exp_bits.size() == 0) check("bit_synch_spurious", bit_synch_o, 0);
         else check("bit_o", bit_o, exp_bits.pop_front());
      end
      if (frame_done_o) begin
         if (exp_ferr.size() == 0) check("frame_done_spurious", frame_done_o, 0);
         else check("frame_err", frame_err_o, exp_ferr.pop_front());
      end
      if (start_err_o) n_serr++;
   endtask

   // abort: 0 none, 1 rst, 2 enable low -- applied at data bit 3, cnt 9
   task automatic send_frame(input logic [7:0] data, input logic par_en, input logic par_val,
                             input logic stop_val, input int glitch_bit, input int abort);
      logic v;
      p_ParityEnable_i = par_en;
      tick(1'b1);
      tick(1'b1);
      n_sync = 0;
      par_ticks = 0;
      seen = 5'b00000;
      tick(1'b0);
      check("start_entry_state", state_o, ST_START);
      check("start_entry_ferr_clr", frame_err_o, 0);
      p_ParityEnable_i = ~par_en;
      for (int k = 1; k < 16; k++) tick(1'b0);
      for (int b = 0; b < (par_en ? 9 : 8); b++) begin
         v = (b < 8) ? data[b] : par_val;
         exp_bits.push_back(v);
         for (int k = 0; k < 16; k++) begin
            if (abort != 0 && b == 3 && k == 10) begin
               check("pre_abort_state", state_o, ST_DATA);
               check("pre_abort_cnt", bit_width_cnt_o, 9);
               if (abort == 1) rst = 1'b1;
               else enable_i = 1'b0;
               tick(v);
               check("abort_state", state_o, ST_IDLE);
               check("abort_cnt", bit_width_cnt_o, 0);
               check("abort_strobes", {bit_synch_o, frame_done_o, start_err_o}, 0);
               check("abort_bit_o", bit_o, 1);
               check("abort_bits_drained", exp_bits.size(), 0);
               rst = 1'b0;
               enable_i = 1'b1;
               return;
            end
            tick((b == glitch_bit && k == 7) ? ~v : v);
         end
      end
      exp_ferr.push_back(~stop_val);
      for (int k = 0; k < 16; k++) tick(stop_val);
      for (int k = 0; k < 4; k++) tick(1'b1);
      check("sync_count", n_sync, par_en ? 9 : 8);
      check("parity_ticks", par_ticks, par_en ? 16 : 0);
      check("end_state_idle", state_o, ST_IDLE);
      check("ferr_drained", exp_ferr.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      enable_i = 1'b1;
      baud_tick_i = 1'b1;
      p_ParityEnable_i = 1'b0;
      rx_i = 1'b1;
      n_serr = 0;
      n_sync = 0;
      seen = 5'b00000;
      par_ticks = 0;
      // Ticks and a falling line during reset must be ignored.
      @(posedge clk);
      #1;
      rx_i = 1'b0;
      @(posedge clk);
      #1;
      check("rst_state", state_o, ST_IDLE);
      check("rst_cnt", bit_width_cnt_o, 0);
      check("rst_bit_o", bit_o, 1);
      check("rst_strobes", {bit_synch_o, frame_done_o, start_err_o, frame_err_o, busy_o}, 0);
      rx_i = 1'b1;
      rst = 1'b0;

      // No tick: a falling edge must not start a frame.
      baud_tick_i = 1'b0;
      @(posedge clk);
      #1;
      rx_i = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("no_tick_idle", state_o, ST_IDLE);
      rx_i = 1'b1;
      baud_tick_i = 1'b1;

      // 8N1 0x55
      send_frame(8'h55, 1'b0, 1'b0, 1'b1, -1, 0);
      check("states_seen_8n1", seen, 5'b10111);

      // False start: low 4 ticks then high
      tick(1'b1);
      tick(1'b1);
      n_sync = 0;
      n_serr = 0;
      for (int k = 0; k < 20; k++) begin
         tick(k < 4 ? 1'b0 : 1'b1);
         if (k == 0) check("fs_state_start", state_o, ST_START);
         check("start_err_at_cnt7", start_err_o, k == 8);
      end
      check("fs_serr_count", n_serr, 1);
      check("fs_no_sync", n_sync, 0);
      check("fs_idle", state_o, ST_IDLE);

      // Parity frame 0xA3 + parity 0
      send_frame(8'hA3, 1'b1, 1'b0, 1'b1, -1, 0);

      // Stop bit 0 -> framing error, held until the next start
      send_frame(8'h5A, 1'b0, 1'b0, 1'b0, -1, 0);
      check("ferr_held", frame_err_o, 1);
      send_frame(8'h0F, 1'b0, 1'b0, 1'b1, -1, 0);
      check("ferr_after_good", frame_err_o, 0);

      // Glitch inside a '1' data bit
      send_frame(8'h01, 1'b0, 1'b0, 1'b1, 0, 0);

      // Mid-frame reset, then a clean frame
      send_frame(8'h55, 1'b0, 1'b0, 1'b1, -1, 1);
      send_frame(8'h3C, 1'b0, 1'b0, 1'b1, -1, 0);

      // Mid-frame disable, then a clean frame
      send_frame(8'h55, 1'b0, 1'b0, 1'b1, -1, 2);
      send_frame(8'h3C, 1'b0, 1'b0, 1'b1, -1, 0);

      check("bits_q_empty", exp_bits.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
